// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU control encodings and helpers used by the ALU share arbiter
// and by any unit that drives the shared ALU datapath.
package alu_share_arbiter_pkg;

   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_ADD  = 4'h0;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SUB  = 4'h1;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLT  = 4'h2;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLTU = 4'h3;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_GE   = 4'h4;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_GEU  = 4'h5;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_AND  = 4'h6;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_OR   = 4'h7;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_XOR  = 4'h8;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SLL  = 4'h9;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRL  = 4'hA;
   localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_SRA  = 4'hB;

   function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] op);
      logic ok;
      case (op)
         ALU_CTRL_ADD, ALU_CTRL_SUB, ALU_CTRL_SLT, ALU_CTRL_SLTU,
         ALU_CTRL_GE,  ALU_CTRL_GEU, ALU_CTRL_AND, ALU_CTRL_OR,
         ALU_CTRL_XOR, ALU_CTRL_SLL, ALU_CTRL_SRL, ALU_CTRL_SRA: ok = 1'b1;
         default:                                                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping modulo N). Reusable for any shared unit.
module rr_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic             found_s;
   logic [PTR_W-1:0] idx_s;

   // Walk from ptr; the first valid requester claims the grant
   always_comb begin
      gnt     = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < N; k++) begin
         idx_s      = PTR_W'((int'(ptr) + k) % N);
         gnt[idx_s] = gnt[idx_s] | (req[idx_s] & !found_s);
         found_s    = found_s | req[idx_s];
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters with
// round-robin arbitration and a single registered result stage.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4,
   parameter int ID_W    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*32-1:0]         req_src1,
   input  logic [NUM_REQ*32-1:0]         req_src2,
   input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_op,
   input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
   output logic [31:0]                   alu_src1,
   output logic [31:0]                   alu_src2,
   output logic [ALU_CTRL_W-1:0]         alu_op,
   input  logic [31:0]                   alu_result,
   input  logic                          alu_zero,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [TAG_W-1:0]              rsp_tag,
   output logic [31:0]                   rsp_result,
   output logic                          rsp_zero,
   output logic                          rsp_err
);

   logic [ID_W-1:0]       rr_ptr_r;
   logic [NUM_REQ-1:0]    gnt_s;
   logic                  slot_free_s;
   logic                  fire_s;
   logic                  op_legal_s;
   logic [ID_W-1:0]       fire_id_s;
   logic [ID_W-1:0]       next_ptr_s;
   logic [31:0]           sel_src1_s;
   logic [31:0]           sel_src2_s;
   logic [ALU_CTRL_W-1:0] sel_op_s;
   logic [TAG_W-1:0]      sel_tag_s;

   rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_rr (
      .req (req_valid),
      .ptr (rr_ptr_r),
      .gnt (gnt_s)
   );

   assign slot_free_s = !rsp_valid || rsp_ready;
   assign req_ready   = gnt_s & {NUM_REQ{slot_free_s & !rst}};
   assign fire_s      = |req_ready;

   // One-hot AND-OR select; no grant yields all-zero fields (ADD)
   always_comb begin
      sel_src1_s = '0;
      sel_src2_s = '0;
      sel_op_s   = '0;
      sel_tag_s  = '0;
      fire_id_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_src1_s = sel_src1_s | ({32{gnt_s[i]}} & req_src1[32*i +: 32]);
         sel_src2_s = sel_src2_s | ({32{gnt_s[i]}} & req_src2[32*i +: 32]);
         sel_op_s   = sel_op_s   | ({ALU_CTRL_W{gnt_s[i]}} & req_op[ALU_CTRL_W*i +: ALU_CTRL_W]);
         sel_tag_s  = sel_tag_s  | ({TAG_W{gnt_s[i]}} & req_tag[TAG_W*i +: TAG_W]);
         fire_id_s  = fire_id_s  | (gnt_s[i] ? ID_W'(i) : {ID_W{1'b0}});
      end
   end

   assign op_legal_s = alu_op_legal(sel_op_s);
   assign alu_src1   = sel_src1_s;
   assign alu_src2   = sel_src2_s;
   assign alu_op     = op_legal_s ? sel_op_s : ALU_CTRL_ADD;
   assign next_ptr_s = (fire_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : fire_id_s + ID_W'(1);

   // Result register and round-robin pointer; both move only on fire
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_tag    <= '0;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         rr_ptr_r   <= '0;
      end else if (fire_s) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= fire_id_s;
         rsp_tag    <= sel_tag_s;
         rsp_result <= op_legal_s ? alu_result : 32'd0;
         rsp_zero   <= op_legal_s ? alu_zero : 1'b1;
         rsp_err    <= !op_legal_s;
         rr_ptr_r   <= next_ptr_s;
      end else if (slot_free_s) begin
         rsp_valid  <= 1'b0;
      end else begin
         rsp_valid  <= rsp_valid;
      end
   end

endmodule
